// File: rtl/control_sequencer.sv
// control_sequencer: T0..T4 microsequencer driving the bus/register/ALU control lines.
// Optional SEQ_EARLY_END_EN: return to T0 right after an instruction's last active step.
module control_sequencer #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N/2-1:0] opcode,
    input  logic           run,
    output logic           pc_oe,
    output logic           pc_inc,
    output logic           pc_load,
    output logic           mar_load,
    output logic           ram_oe,
    output logic           ram_we,
    output logic           load_ir,
    output logic           output_enable_ir,
    output logic           a_load,
    output logic           a_oe,
    output logic           b_load,
    output logic           alu_oe,
    output logic           alu_sub,
    output logic           out_load,
    output logic [2:0]     tstate,
    output logic           halted
);
    typedef enum logic [2:0] {T0, T1, T2, T3, T4} t_state_e;
    localparam logic [N/2-1:0] OP_LDA = (N/2)'(1);
    localparam logic [N/2-1:0] OP_ADD = (N/2)'(2);
    localparam logic [N/2-1:0] OP_SUB = (N/2)'(3);
    localparam logic [N/2-1:0] OP_STA = (N/2)'(4);
    localparam logic [N/2-1:0] OP_LDI = (N/2)'(5);
    localparam logic [N/2-1:0] OP_JMP = (N/2)'(6);
    localparam logic [N/2-1:0] OP_OUT = (N/2)'(14);
    localparam logic [N/2-1:0] OP_HLT = (N/2)'(15);
    t_state_e state, next_state;
    logic next_halted;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= T0;
            halted <= 1'b0;
        end else begin
            state  <= next_state;
            halted <= next_halted;
        end
    end
    assign tstate = state;
    // rst_n gates the decode so fetch controls stay low while reset is held
    always_comb begin
        next_state       = state;
        next_halted      = halted;
        pc_oe            = 1'b0;
        pc_inc           = 1'b0;
        pc_load          = 1'b0;
        mar_load         = 1'b0;
        ram_oe           = 1'b0;
        ram_we           = 1'b0;
        load_ir          = 1'b0;
        output_enable_ir = 1'b0;
        a_load           = 1'b0;
        a_oe             = 1'b0;
        b_load           = 1'b0;
        alu_oe           = 1'b0;
        alu_sub          = 1'b0;
        out_load         = 1'b0;
        if (rst_n && run && !halted) begin
            next_state = (state == T4) ? T0 : t_state_e'(state + 3'd1);
            unique case (state)
                T0: begin
                    pc_oe    = 1'b1;
                    mar_load = 1'b1;
                end
                T1: begin
                    ram_oe  = 1'b1;
                    load_ir = 1'b1;
                    pc_inc  = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            output_enable_ir = 1'b1;
                            mar_load         = 1'b1;
                        end
                        OP_LDI: begin
                            output_enable_ir = 1'b1;
                            a_load           = 1'b1;
                        end
                        OP_JMP: begin
                            output_enable_ir = 1'b1;
                            pc_load          = 1'b1;
                        end
                        OP_OUT: begin
                            a_oe     = 1'b1;
                            out_load = 1'b1;
                        end
                        OP_HLT: begin
                            next_halted = 1'b1;
                            next_state  = T2;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_oe = 1'b1;
                            a_load = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_oe = 1'b1;
                            b_load = 1'b1;
                        end
                        OP_STA: begin
                            a_oe   = 1'b1;
                            ram_we = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    alu_oe  = (opcode == OP_ADD) || (opcode == OP_SUB);
                    a_load  = (opcode == OP_ADD) || (opcode == OP_SUB);
                    alu_sub = (opcode == OP_SUB);
                end
                default: next_state = T0;
            endcase
`ifdef SEQ_EARLY_END_EN
            if ((state == T2 && !(opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_HLT})) ||
                (state == T3 && (opcode inside {OP_LDA, OP_STA})))
                next_state = T0;
`endif
        end
    end
endmodule
